// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// ALU operation codes and datapath mux select codes.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_ERROR    = 4'd11
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // Immediate format depends only on the opcode, so it is decoded outside the FSM.
  function automatic logic [1:0] imm_src_for(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src_for = IMM_S;
      OP_BEQ:  imm_src_for = IMM_B;
      OP_JAL:  imm_src_for = IMM_J;
      default: imm_src_for = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps the FSM's coarse ALU request plus instruction funct fields onto the
// datapath ALU control code.
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type uses funct7 to select sub; addi's immediate bit 30 must not.
          3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alu_control = ALU_SLT;
          3'b110:  alu_control = ALU_OR;
          3'b111:  alu_control = ALU_AND;
          default: alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: one state register, outputs
// decoded combinationally from state, zero and mem_ready.
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic       reg_write,
  output logic       illegal_op
);

  state_e     state_q, state_d;
  logic [1:0] alu_op;
  logic       pc_update;
  logic       branch;
  logic       ir_load;
  logic       mem_wr;
  logic       rf_wr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BEQ;
          OP_JAL:       state_d = S_JAL;
          default:      state_d = S_ERROR;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_ERROR:    state_d = S_ERROR;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    mem_req    = 1'b0;
    adr_src    = 1'b0;
    mem_wr     = 1'b0;
    ir_load    = 1'b0;
    rf_wr      = 1'b0;
    pc_update  = 1'b0;
    branch     = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RD2;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_a  = SRCA_PC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALURESULT;
        ir_load    = mem_ready;
        pc_update  = mem_ready;
      end
      // Precompute the branch/jump target into ALUOut while the register file reads.
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: begin
        mem_req    = 1'b1;
        adr_src    = 1'b1;
        result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        result_src = RES_DATA;
        rf_wr      = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        mem_wr  = 1'b1;
      end
      S_EXECR: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_RD2;
        alu_op    = ALUOP_FUNCT;
      end
      S_EXECI: begin
        alu_src_a = SRCA_RD1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        rf_wr      = 1'b1;
      end
      S_BEQ: begin
        alu_src_a  = SRCA_RD1;
        alu_src_b  = SRCB_RD2;
        alu_op     = ALUOP_SUB;
        result_src = RES_ALUOUT;
        branch     = 1'b1;
      end
      // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALUOUT;
        pc_update  = 1'b1;
      end
      S_ERROR:  illegal_op = 1'b1;
      default: ;
    endcase
  end

  // Strobes are gated by rst_n so nothing writes while reset is held, even with mem_ready high.
  assign pc_write  = (pc_update | (branch & zero)) & rst_n;
  assign ir_write  = ir_load & rst_n;
  assign mem_write = mem_wr & rst_n;
  assign reg_write = rf_wr & rst_n;
  assign imm_src   = imm_src_for(op);

  alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct3      (funct3),
    .op5         (op[5]),
    .funct7b5    (funct7b5),
    .alu_control (alu_control)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed, table-driven bench for multicycle_controller with hand-computed
// per-cycle expected outputs and a few reset corner sequences.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op = 7'b0000011;
  logic [2:0] funct3 = 3'b010;
  logic       funct7b5 = 1'b0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
  logic [2:0] alu_control;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op          (op),
    .funct3      (funct3),
    .funct7b5    (funct7b5),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .pc_write    (pc_write),
    .adr_src     (adr_src),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .result_src  (result_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .imm_src     (imm_src),
    .alu_control (alu_control),
    .reg_write   (reg_write),
    .illegal_op  (illegal_op)
  );

  // Strobe order: mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op
  typedef struct {
    string       tag;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        z;
    logic        rdy;
    logic [17:0] exp;
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111, BAD = 7'b1111111;

  function automatic logic [6:0] strobes();
    return {mem_req, pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op};
  endfunction

  function automatic logic [17:0] all_outs();
    return {strobes(), result_src, alu_src_a, alu_src_b, imm_src, alu_control};
  endfunction

  task automatic add(input string tag, input logic [6:0] o, input logic [2:0] f3,
                     input logic f7, input logic z, input logic rdy, input logic [6:0] strb,
                     input logic [1:0] rs, input logic [1:0] sa, input logic [1:0] sb,
                     input logic [1:0] imm, input logic [2:0] alu);
    vec_t v;
    v.tag = tag; v.op = o; v.f3 = f3; v.f7 = f7; v.z = z; v.rdy = rdy;
    v.exp = {strb, rs, sa, sb, imm, alu};
    vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    // lw, memory always ready: FETCH DECODE MEMADR MEMREAD MEMWB
    add("lw_fetch",  LW, 3'b010, 1'b0, 1'b0, 1'b1, 7'b1100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add("lw_decode", LW, 3'b010, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    add("lw_memadr", LW, 3'b010, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    add("lw_memrd",  LW, 3'b010, 1'b0, 1'b0, 1'b1, 7'b1010000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    add("lw_memwb",  LW, 3'b010, 1'b0, 1'b0, 1'b1, 7'b0000010, 2'b01, 2'b00, 2'b00, 2'b00, 3'b000);
    // sw: fetch stalls once, mem_ready low in DECODE/MEMADR is ignored, write held 3 cycles
    add("sw_fstall", SW, 3'b010, 1'b0, 1'b0, 1'b0, 7'b1000000, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
    add("sw_fetch",  SW, 3'b010, 1'b0, 1'b0, 1'b1, 7'b1100100, 2'b10, 2'b00, 2'b10, 2'b01, 3'b000);
    add("sw_decode", SW, 3'b010, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b01, 3'b000);
    add("sw_memadr", SW, 3'b010, 1'b0, 1'b0, 1'b0, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b01, 3'b000);
    for (int k = 0; k < 3; k++)
      add("sw_wait", SW, 3'b010, 1'b0, 1'b0, 1'b0, 7'b1011000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
    add("sw_done",   SW, 3'b010, 1'b0, 1'b0, 1'b1, 7'b1011000, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000);
    // beq taken then not taken
    add("beq1_fetch", BQ, 3'b000, 1'b0, 1'b1, 1'b1, 7'b1100100, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000);
    add("beq1_dec",   BQ, 3'b000, 1'b0, 1'b1, 1'b1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000);
    add("beq1_exec",  BQ, 3'b000, 1'b0, 1'b1, 1'b1, 7'b0100000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
    add("beq0_fetch", BQ, 3'b000, 1'b0, 1'b0, 1'b1, 7'b1100100, 2'b10, 2'b00, 2'b10, 2'b10, 3'b000);
    add("beq0_dec",   BQ, 3'b000, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b10, 3'b000);
    add("beq0_exec",  BQ, 3'b000, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b10, 2'b00, 2'b10, 3'b001);
    // R-type sub
    add("sub_fetch", RT, 3'b000, 1'b1, 1'b0, 1'b1, 7'b1100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add("sub_dec",   RT, 3'b000, 1'b1, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    add("sub_exec",  RT, 3'b000, 1'b1, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b001);
    add("sub_wb",    RT, 3'b000, 1'b1, 1'b0, 1'b1, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    // addi with bit 30 set stays add
    add("addi_fetch", IT, 3'b000, 1'b1, 1'b0, 1'b1, 7'b1100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add("addi_dec",   IT, 3'b000, 1'b1, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    add("addi_exec",  IT, 3'b000, 1'b1, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000);
    add("addi_wb",    IT, 3'b000, 1'b1, 1'b0, 1'b1, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    // R-type and / or, slti: funct3 decode
    add("and_fetch", RT, 3'b111, 1'b0, 1'b0, 1'b1, 7'b1100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add("and_dec",   RT, 3'b111, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    add("and_exec",  RT, 3'b111, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b10, 2'b00, 2'b00, 3'b010);
    add("or_wb",     RT, 3'b110, 1'b0, 1'b0, 1'b1, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    add("slti_fetch", IT, 3'b010, 1'b0, 1'b0, 1'b1, 7'b1100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add("slti_dec",   IT, 3'b010, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    add("or_exec",    IT, 3'b110, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b011);
    add("xor_wb",     IT, 3'b100, 1'b0, 1'b0, 1'b1, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    add("slt_fetch",  IT, 3'b010, 1'b0, 1'b0, 1'b1, 7'b1100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add("slt_dec",    IT, 3'b010, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    add("slt_exec",   IT, 3'b010, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b101);
    add("slt_wb",     IT, 3'b010, 1'b0, 1'b0, 1'b1, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);
    // jal: FETCH DECODE JAL ALUWB
    add("jal_fetch", JL, 3'b000, 1'b0, 1'b0, 1'b1, 7'b1100100, 2'b10, 2'b00, 2'b10, 2'b11, 3'b000);
    add("jal_dec",   JL, 3'b000, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b11, 3'b000);
    add("jal_exec",  JL, 3'b000, 1'b0, 1'b0, 1'b1, 7'b0100000, 2'b00, 2'b01, 2'b10, 2'b11, 3'b000);
    add("jal_wb",    JL, 3'b000, 1'b0, 1'b0, 1'b1, 7'b0000010, 2'b00, 2'b00, 2'b00, 2'b11, 3'b000);
    // illegal opcode: ERROR holds for 10 cycles regardless of inputs
    add("bad_fetch", BAD, 3'b000, 1'b0, 1'b0, 1'b1, 7'b1100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000);
    add("bad_dec",   BAD, 3'b000, 1'b0, 1'b0, 1'b1, 7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000);
    for (int k = 0; k < 10; k++)
      add("bad_err", BAD, 3'b000, 1'b0, k[0], 1'b1, 7'b0000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000);

    // Reset held with mem_ready high: fetch address presented, no strobes
    repeat (2) @(negedge clk);
    #1 check("reset_hold", {11'd0, strobes()}, {11'd0, 7'b1000000});
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      op = vq[i].op; funct3 = vq[i].f3; funct7b5 = vq[i].f7;
      zero = vq[i].z; mem_ready = vq[i].rdy;
      #1 check($sformatf("%s[%0d]", vq[i].tag, i), all_outs(), vq[i].exp);
    end

    // Reset out of ERROR clears illegal_op
    @(negedge clk);
    rst_n = 1'b0;
    op = LW; funct3 = 3'b010; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
    #1 check("err_reset", {11'd0, strobes()}, {11'd0, 7'b1000000});

    // lw interrupted by reset in the middle of a stalled MEMREAD
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("mr_fetch", all_outs(), {7'b1100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000});
    @(negedge clk);
    #1 check("mr_decode", all_outs(), {7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000});
    @(negedge clk);
    mem_ready = 1'b0;
    #1 check("mr_memadr", all_outs(), {7'b0000000, 2'b00, 2'b10, 2'b01, 2'b00, 3'b000});
    @(negedge clk);
    #1 check("mr_stall", all_outs(), {7'b1010000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000});
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check("mr_async_rst", {11'd0, strobes()}, {11'd0, 7'b1000000});
    @(negedge clk);
    rst_n = 1'b1;
    mem_ready = 1'b1;
    #1 check("mr_refetch", all_outs(), {7'b1100100, 2'b10, 2'b00, 2'b10, 2'b00, 3'b000});
    @(negedge clk);
    #1 check("mr_redecode", all_outs(), {7'b0000000, 2'b00, 2'b01, 2'b01, 2'b00, 3'b000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
